// File: rtl/mem_arbiter.sv
// mem_arbiter: hands the single-port pipelined main memory to the I-cache or D-cache
// refill FSM for a whole burst, keeping ownership until every read in flight has returned.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_data_vld,
    output logic              i_wait,
    input  logic              d_read_req,
    input  logic              d_wrt,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_data_vld,
    output logic              d_wr_ack,
    output logic              d_wait,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid
);

    localparam int               CNT_W   = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LAT);

    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_D,
        DRAIN_I,
        DRAIN_D
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             last_d, last_d_nxt;
    logic             d_req;
    logic             gnt_i, gnt_d, own_i, own_d;
    logic             rd_issue, vld_take;

    assign d_req    = d_read_req | d_wrt;
    assign gnt_i    = (state == GNT_I);
    assign gnt_d    = (state == GNT_D);
    assign own_i    = gnt_i | (state == DRAIN_I);
    assign own_d    = gnt_d | (state == DRAIN_D);
    // A store always wins over a simultaneous D read, so only a store-free cycle issues a read
    assign rd_issue = (gnt_i & i_read_req) | (gnt_d & d_read_req & ~d_wrt);
    assign vld_take = mem_data_valid & (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            last_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        count_nxt = count;
        if (rd_issue && !vld_take && count != CNT_MAX) begin
            count_nxt = count + CNT_W'(1);
        end else if (!rd_issue && vld_take) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Exit decisions use the post-update count so the port frees the cycle after the last valid
    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        case (state)
            IDLE: begin
                if (i_read_req && d_req) begin
                    state_nxt = last_d ? GNT_I : GNT_D;
                end else if (d_req) begin
                    state_nxt = GNT_D;
                end else if (i_read_req) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I: begin
                if (!i_read_req) begin
                    state_nxt  = (count_nxt == '0) ? IDLE : DRAIN_I;
                    last_d_nxt = 1'b0;
                end
            end
            GNT_D: begin
                if (!d_req) begin
                    state_nxt  = (count_nxt == '0) ? IDLE : DRAIN_D;
                    last_d_nxt = 1'b1;
                end
            end
            DRAIN_I, DRAIN_D: begin
                if (count_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        d_wr_ack   = 1'b0;
        if (gnt_i) begin
            mem_enable = i_read_req;
            mem_addr   = i_addr;
        end else if (gnt_d) begin
            mem_enable = d_req;
            mem_addr   = d_addr;
            mem_wr     = d_wrt;
            d_wr_ack   = d_wrt;
            if (d_wrt) begin
                mem_wdata = d_wdata;
            end
        end
    end

    // Waits are masked by reset so every output reads 0 while reset is held
    assign i_data_vld = mem_data_valid & own_i;
    assign d_data_vld = mem_data_valid & own_d;
    assign i_wait     = rst & i_read_req & ~gnt_i;
    assign d_wait     = rst & ((d_req & ~gnt_d) | (gnt_d & d_wrt & d_read_req));

    property p_no_overflow;
        @(posedge clk) disable iff (!rst)
            !(rd_issue && !mem_data_valid && count == CNT_MAX);
    endproperty
    a_no_overflow: assert property (p_no_overflow);

endmodule
